// File: rtl/bsg_dff_async_reset.sv
// ----------------------------------------------------------------------------
// bsg_dff_async_reset
//
// Register pipeline of els_p stages, each width_p bits wide, with an
// asynchronous active-low reset that loads reset_val_p into every stage.
// A saturating fill counter drives valid_o once els_p enabled edges have
// occurred since reset release, so downstream logic can tell post-reset
// data apart from the reset value.
//
// Parameters:
//   width_p     - data width in bits (>= 1)
//   els_p       - number of pipeline stages (>= 1)
//   reset_val_p - value loaded into every stage while reset is asserted
//
// Ports:
//   clk_i    - clock, all state changes on the rising edge
//   reset_li - reset, asynchronous, active-low
//   en_i     - shift enable; when low every stage and the counter hold
//   data_i   - word captured into stage 0 on an enabled edge
//   data_o   - contents of the last stage
//   valid_o  - high once the pipe has been filled after reset release
//
// Optional build macro: BSG_DFF_ASYNC_RESET_SYNC_EN
//   When defined, reset_li passes through a 2-flop reset synchronizer
//   (asynchronous assert, synchronous deassert). The first capture edge is
//   then the third rising edge after reset_li rises. When undefined,
//   reset_li drives the stage and counter resets directly.
// ----------------------------------------------------------------------------
module bsg_dff_async_reset #(
    parameter int                 width_p     = 1,
    parameter int                 els_p       = 1,
    parameter logic [width_p-1:0] reset_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_li,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o,
    output logic               valid_o
);

    localparam int                  cnt_w_lp   = $clog2(els_p + 1);
    localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(els_p);
    localparam logic [cnt_w_lp-1:0] cnt_one_lp = cnt_w_lp'(1);

    // Internal active-low reset seen by the stages and the counter.
    logic rst_n_s;

`ifdef BSG_DFF_ASYNC_RESET_SYNC_EN
    logic [1:0] sync_q;

    // Reset synchronizer: clears immediately on reset_li low, releases
    // after a one shifts through both flops.
    always_ff @(posedge clk_i or negedge reset_li) begin
        if (!reset_li) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rst_n_s = sync_q[1];
`else
    assign rst_n_s = reset_li;
`endif

    logic [els_p-1:0][width_p-1:0] stage_q;
    logic [els_p-1:0][width_p-1:0] stage_d;
    logic [cnt_w_lp-1:0]           cnt_q;
    logic [cnt_w_lp-1:0]           cnt_d;

    // Next-state for the shift register: shift by one on enable, else hold.
    always_comb begin
        stage_d = stage_q;
        if (en_i) begin
            stage_d[0] = data_i;
            for (int k = 1; k < els_p; k++) begin
                stage_d[k] = stage_q[k-1];
            end
        end else begin
            stage_d = stage_q;
        end
    end

    // Next-state for the fill counter: count enabled edges, saturate at els_p.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != cnt_max_lp)) begin
            cnt_d = cnt_q + cnt_one_lp;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Stage registers with asynchronous reset to reset_val_p.
    always_ff @(posedge clk_i or negedge rst_n_s) begin
        if (!rst_n_s) begin
            stage_q <= {els_p{reset_val_p}};
        end else begin
            stage_q <= stage_d;
        end
    end

    // Fill counter register with asynchronous reset to zero.
    always_ff @(posedge clk_i or negedge rst_n_s) begin
        if (!rst_n_s) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign data_o  = stage_q[els_p-1];
    // Compare on the registered counter keeps valid_o free of input paths.
    assign valid_o = (cnt_q == cnt_max_lp);

endmodule

// File: tb/tb_bsg_dff_async_reset.sv
// ----------------------------------------------------------------------------
// tb_bsg_dff_async_reset
//
// Two instances: an 8-bit, 3-stage pipe with reset value A5 and a 1-bit,
// 1-stage pipe with reset value 0. The reference model keeps the list of
// words accepted since the last reset release; the expected output is the
// word accepted els_p captures ago, or the reset value if fewer exist.
// ----------------------------------------------------------------------------
module tb_bsg_dff_async_reset;

`ifdef BSG_DFF_ASYNC_RESET_SYNC_EN
    localparam int SKIP = 2;
`else
    localparam int SKIP = 0;
`endif

    logic       clk;
    logic       reset_li;
    logic       en_i;
    logic [7:0] data_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       data1_i;
    logic       data1_o;
    logic       valid1_o;

    bsg_dff_async_reset #(
        .width_p    (8),
        .els_p      (3),
        .reset_val_p(8'hA5)
    ) dut (
        .clk_i   (clk),
        .reset_li(reset_li),
        .en_i    (en_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .valid_o (valid_o)
    );

    bsg_dff_async_reset #(
        .width_p    (1),
        .els_p      (1),
        .reset_val_p(1'b0)
    ) dut1 (
        .clk_i   (clk),
        .reset_li(reset_li),
        .en_i    (en_i),
        .data_i  (data1_i),
        .data_o  (data1_o),
        .valid_o (valid1_o)
    );

    typedef struct {
        logic [7:0] d;
        logic       v;
        logic       d1;
        logic       v1;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] hist[$];
    logic       hist1[$];
    int         skip;
    logic       cur_rst;
    logic       cur_en;
    logic [7:0] cur_d;
    logic       cur_d1;
    int         checks;
    int         failures;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, req, $time);
        end
    endtask

    // Apply the model for the edge just taken, then drive new inputs and
    // push what the outputs must show at the following falling edge.
    task automatic step(input logic rst_n, input logic en, input logic [7:0] d, input logic d1);
        exp_t e;
        int   n;
        @(posedge clk);
        if (cur_rst) begin
            if (skip > 0) begin
                skip--;
            end else if (cur_en) begin
                hist.push_back(cur_d);
                hist1.push_back(cur_d1);
            end
        end
        #1;
        reset_li = rst_n;
        en_i     = en;
        data_i   = d;
        data1_i  = d1;
        cur_rst  = rst_n;
        cur_en   = en;
        cur_d    = d;
        cur_d1   = d1;
        if (!rst_n) begin
            hist.delete();
            hist1.delete();
            skip = SKIP;
        end
        n    = hist.size();
        e.v  = (n >= 3);
        e.d  = e.v ? hist[n-3] : 8'hA5;
        n    = hist1.size();
        e.v1 = (n >= 1);
        e.d1 = e.v1 ? hist1[n-1] : 1'b0;
        exp_q.push_back(e);
    endtask

    // Monitor: compare every sample against the oldest expected entry.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("data_o",   data_o,         e.d);
                chk("valid_o",  {7'd0, valid_o}, {7'd0, e.v});
                chk("data1_o",  {7'd0, data1_o}, {7'd0, e.d1});
                chk("valid1_o", {7'd0, valid1_o}, {7'd0, e.v1});
            end
        end
    end

    initial begin : driver
        checks   = 0;
        failures = 0;
        skip     = SKIP;
        reset_li = 1'b1;
        en_i     = 1'b0;
        data_i   = 8'h00;
        data1_i  = 1'b0;
        cur_rst  = 1'b0;
        cur_en   = 1'b0;
        cur_d    = 8'h00;
        cur_d1   = 1'b0;
        #2;
        reset_li = 1'b0;

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 8'($urandom), 1'($urandom));
        end
        // Directed fill, stall and refill sequence.
        step(1'b1, 1'b1, 8'd1, 1'b1);
        step(1'b1, 1'b1, 8'd2, 1'b0);
        step(1'b1, 1'b1, 8'd3, 1'b1);
        step(1'b1, 1'b1, 8'd4, 1'b0);
        step(1'b1, 1'b1, 8'd5, 1'b1);
        step(1'b1, 1'b0, 8'hEE, 1'b0);
        step(1'b1, 1'b0, 8'hDD, 1'b0);
        step(1'b1, 1'b1, 8'd6, 1'b0);
        step(1'b1, 1'b1, 8'd7, 1'b1);
        step(1'b1, 1'b1, 8'd8, 1'b0);
        // Reset while full, checked before the next rising edge.
        step(1'b0, 1'b1, 8'd9, 1'b1);
        step(1'b0, 1'b1, 8'd10, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 8'(8'd20 + 8'(i)), 1'(i));
        end
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 39) != 0), ($urandom_range(0, 3) != 0),
                 8'($urandom), 1'($urandom));
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bsg_dff_async_reset.md
# bsg_dff_async_reset

Parameterized register pipeline with an asynchronous, active-low reset. It delays a `width_p`-bit word by `els_p` enabled clock edges, and every stage is forced to a programmable reset value. A `valid_o` flag marks when the output carries post-reset data rather than the reset value. It is a general-purpose building block: the nonsynth profilers use a one-bit, one-stage instance to delay the read-valid strobe by one cycle.

## Interface
- `width_p`, default 1: data width in bits; must be ≥1.
- `els_p`, default 1: number of pipeline stages; must be ≥1.
- `reset_val_p`, default 0 (`width_p` bits): value loaded into every stage during reset.
- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `reset_li`, input, 1: reset, asynchronous, active-low.
- `en_i`, input, 1: shift enable; when low, all stages and the counter hold.
- `data_i`, input, `width_p`: word captured into stage 0.
- `data_o`, output, `width_p`: contents of stage `els_p`-1.
- `valid_o`, output, 1: high once `els_p` enabled edges have occurred since reset release.

## Operation
- Stages s[0..els_p-1], each `width_p` bits wide.
- On an enabled edge, s[0] takes `data_i` and each s[k] takes the old value of s[k-1] (shift register).
- On a non-enabled edge, nothing changes.
- Fill counter `cnt_r` is `$clog2(els_p+1)` bits wide:
  - increments on each enabled edge out of reset;
  - saturates at `els_p` and never wraps.
- `valid_o` = (`cnt_r == els_p`), decoded combinationally from the registered counter.
- Reset (internal reset asserted) forces:
  - all stages to `reset_val_p`, so `data_o` = `reset_val_p`;
  - `cnt_r` to 0, so `valid_o` = 0.
- Reset assertion takes effect immediately, with no clock required. This holds mid-operation too: in-flight data is discarded.
- Reset has priority over `en_i`.
- The stage logic carries no X-propagation guarding. `data_i` containing X propagates as-is.
- `els_p`=1 degenerates to a single enabled DFF with reset.

## Timing
- Latency: with `en_i` held high, `data_o` after edge n equals `data_i` sampled at edge n-`els_p`+1. Example: `els_p`=1 gives a one-cycle delay.
- Stalls: cycles with `en_i`=0 add one cycle of latency each and do not lose data.
- Reset assertion (falling edge of `reset_li`): outputs reach reset values asynchronously, in the same cycle.
- Reset deassertion, without the macro: the first rising edge after `reset_li` rises is the first capture edge.
- `reset_li` must meet recovery/removal timing relative to `clk_i` unless the synchronizer (see Configuration) is compiled in.
- `valid_o` rises on the `els_p`-th enabled edge after the first capture edge.
- Outputs are purely registered, or a registered-counter compare for `valid_o`. There is no combinational path from inputs to outputs.

## Configuration
- Macro `BSG_DFF_ASYNC_RESET_SYNC_EN`.
- Defined:
  - `reset_li` passes through a 2-flop reset synchronizer: asynchronous assert, synchronous deassert;
  - the synchronizer flops themselves reset asynchronously on `reset_li` low;
  - after `reset_li` rises, the internal reset stays asserted through the next two rising edges, so the first capture edge is the third rising edge;
  - assertion remains immediate.
- Undefined: `reset_li` drives the stage and counter resets directly, and the first capture edge is the first rising edge after release.

## Test plan
- Async reset:
  - Stimulus: `width_p`=8, `els_p`=3, `reset_val_p`=8'hA5; pull `reset_li` low between clock edges.
  - Required: `data_o`=8'hA5 and `valid_o`=0 before the next edge.
- Pipeline latency:
  - Stimulus: release reset, `en_i`=1, drive `data_i` = 1, 2, 3, 4 on successive edges.
  - Required: `data_o` = A5, A5, 1, 2, 3, 4 after each edge in order; `valid_o` rises with the edge that presents value 1.
- Stall:
  - Stimulus: same setup, drop `en_i` for 2 cycles mid-stream.
  - Required: `data_o` and `valid_o` hold; the sequence resumes without loss or duplication.
- Reset mid-stream:
  - Stimulus: assert `reset_li` while the pipe is full, then release.
  - Required: immediate A5 / `valid_o`=0; refill takes 3 enabled edges again.
- Degenerate single stage:
  - Stimulus: `width_p`=1, `els_p`=1, `reset_val_p`=0; toggle `data_i`.
  - Required: `data_o` follows `data_i` one edge later; `valid_o`=1 after the first capture edge.
- Synchronizer on:
  - Stimulus: build with `BSG_DFF_ASYNC_RESET_SYNC_EN`, `els_p`=1, `data_i`=1.
  - Required: `data_o` stays at reset value through two edges after release and becomes 1 on the third.
